fir_delay_line_reader: RTL and testbench

- Serial FIR tap engine for one equalizer band.
- On each sample strobe it writes the new sample into a circular delay line, then reads taps newest-to-oldest, one per cycle.
- Drives the coefficient address for each tap and multiply-accumulates sample × coefficient.
- Emits one rounded Q15 result per input sample, with a one-cycle valid pulse.

---
 rtl/fir_delay_line_reader.sv | 128 ++++++++++++
 tb/tb_fir_delay_line_reader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_delay_line_reader.sv
// Serial FIR tap engine: circular delay line, one MAC per cycle, rounded Q15 output.
// Define FIR_SATURATE_EN to clamp the result to the DATA_W range instead of wrapping.
module fir_delay_line_reader #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 64,
  parameter int ADDR_W = 6,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic        [ADDR_W-1:0] coef_addr,
  output logic signed [DATA_W-1:0] filter_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEF_W - 2);

  logic [1:0]               state_q, state_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]        tap_q, tap_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] filter_q, filter_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;
  logic signed [DATA_W-1:0] mem_q [TAPS];
  logic                     mem_we;
  logic [ADDR_W-1:0]        wr_inc;
  logic signed [PROD_W-1:0] prod;

  assign wr_inc = wr_ptr_q + ADDR_W'(1);
  assign prod   = mem_q[rd_ptr_q] * coef_data;

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [ACC_W-1:0] r_full;
  assign r_full = (acc_q + RND) >>> (COEF_W - 1);
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tap_d     = tap_q;
    acc_d     = acc_q;
    filter_d  = filter_q;
    valid_d   = 1'b0;
    mem_we    = 1'b0;
    overrun_d = overrun_q | (clk_enable && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (clk_enable) begin
          wr_ptr_d = wr_inc;
          mem_we   = 1'b1;
          rd_ptr_d = wr_inc;
          tap_d    = '0;
          acc_d    = '0;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d    = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        tap_d    = tap_q + ADDR_W'(1);
        rd_ptr_d = rd_ptr_q - ADDR_W'(1);
        if (tap_q == ADDR_W'(TAPS - 1)) state_d = S_OUT;
      end
      S_OUT: begin
`ifdef FIR_SATURATE_EN
        if (r_full > SAT_MAX)      filter_d = SAT_MAX[DATA_W-1:0];
        else if (r_full < SAT_MIN) filter_d = SAT_MIN[DATA_W-1:0];
        else                       filter_d = r_full[DATA_W-1:0];
`else
        filter_d = DATA_W'((acc_q + RND) >>> (COEF_W - 1));
`endif
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= ADDR_W'(TAPS - 1);
      rd_ptr_q  <= '0;
      tap_q     <= '0;
      acc_q     <= '0;
      filter_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      // NOTE: the delay line is reset on purpose; taps must read zero history after reset.
      for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tap_q     <= tap_d;
      acc_q     <= acc_d;
      filter_q  <= filter_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      if (mem_we) mem_q[wr_inc] <= sample_in;
    end
  end

  assign coef_addr  = tap_q;
  assign filter_out = filter_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_delay_line_reader.sv
// Self-checking bench for fir_delay_line_reader: vector table, corner sequences, random vs. history model.
module tb_fir_delay_line_reader;

  logic               clk = 1'b0;
  logic               rst;
  logic               clk_enable;
  logic signed [15:0] sample_in;
  logic signed [15:0] coef_data;
  logic        [5:0]  coef_addr;
  logic signed [15:0] filter_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  logic signed [15:0] coef_rom [64];
  longint             hist [64];   // hist[k] = sample accepted k strobes ago
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic signed [15:0] sample;
    logic signed [15:0] exp_out;
  } vec_t;
  vec_t vecs [3];

  always #5 clk = ~clk;
  assign coef_data = coef_rom[coef_addr];

  fir_delay_line_reader dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .sample_in(sample_in),
    .coef_data(coef_data), .coef_addr(coef_addr), .filter_out(filter_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 64; k++) hist[k] = 0;
  endfunction

  function automatic void model_push(input longint s);
    for (int k = 63; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
  endfunction

  function automatic longint model_out();
    longint acc;
    longint r;
    logic signed [15:0] n;
    acc = 0;
    for (int k = 0; k < 64; k++) acc += hist[k] * longint'(coef_rom[k]);
    r = (acc + 16384) >>> 15;
`ifdef FIR_SATURATE_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
`else
    n = r[15:0];
    return longint'(n);
`endif
  endfunction

  function automatic void set_coefs(input int c0, input int c1, input int c63, input int rest);
    for (int k = 0; k < 64; k++) coef_rom[k] = 16'(rest);
    coef_rom[0]  = 16'(c0);
    coef_rom[1]  = 16'(c1);
    coef_rom[63] = 16'(c63);
  endfunction

  task automatic do_reset();
    rst = 1'b0; clk_enable = 1'b0; sample_in = '0;
    #1;
    check("rst_coef_addr", coef_addr, 0);
    check("rst_filter_out", filter_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    step(); step();
    rst = 1'b1;
    model_clear();
    step();
  endtask

  // Waits for out_valid from the current cycle; exp_n is the number of steps it should take.
  task automatic wait_valid(input int exp_n, input string name);
    int n = 0;
    bit busy_bad = 0;
    while (n < 100 && !out_valid) begin
      if (!busy) busy_bad = 1;
      step();
      n++;
    end
    check({name, "_latency"}, n, exp_n);
    check({name, "_busy_window"}, busy_bad, 0);
    check({name, "_busy_low_at_valid"}, busy, 0);
    check({name, "_value"}, filter_out, model_out());
  endtask

  task automatic strobe(input logic signed [15:0] s);
    clk_enable = 1'b1; sample_in = s;
    step();
    clk_enable = 1'b0;
    model_push(longint'(s));
  endtask

  task automatic run_sample(input logic signed [15:0] s, input string name);
    strobe(s);
    wait_valid(65, name);
  endtask

  initial begin
    int    gap;
    bit    saw_valid;
    logic signed [15:0] s;

    // Impulse / latency / minimum spacing
    set_coefs(32767, -16384, 0, 0);
    do_reset();
    vecs[0].sample = 16'sd16384; vecs[0].exp_out = 16'sd16384;
    vecs[1].sample = 16'sd0;     vecs[1].exp_out = -16'sd8192;
    vecs[2].sample = 16'sd0;     vecs[2].exp_out = 16'sd0;
    for (int i = 0; i < 3; i++) begin
      run_sample(vecs[i].sample, $sformatf("impulse%0d", i));
      check($sformatf("impulse%0d_table", i), filter_out, vecs[i].exp_out);
    end
    check("b2b_no_overrun", overrun, 0);
    step();
    check("valid_one_cycle", out_valid, 0);
    check("filter_out_held", filter_out, 0);

    // Delay-line wrap
    set_coefs(0, 0, 32767, 0);
    do_reset();
    for (int i = 1; i <= 65; i++) begin
      run_sample(16'(i), $sformatf("wrap%0d", i));
      check($sformatf("wrap%0d_table", i), filter_out, (i >= 64) ? i - 63 : 0);
    end

    // Overrun
    set_coefs(32767, -16384, 0, 0);
    do_reset();
    strobe(16'sd100);
    for (int i = 0; i < 9; i++) step();
    check("overrun_before", overrun, 0);
    clk_enable = 1'b1; sample_in = 16'sd200;
    step();
    clk_enable = 1'b0;
    check("overrun_set", overrun, 1);
    wait_valid(55, "overrun_result");
    check("overrun_result_const", filter_out, 100);
    run_sample(16'sd0, "overrun_next");
    check("overrun_next_const", filter_out, -50);
    check("overrun_sticky", overrun, 1);

    // Reset mid-operation
    do_reset();
    run_sample(16'sd1000, "prereset");
    strobe(16'sd2000);
    for (int i = 0; i < 29; i++) step();
    rst = 1'b0;
    #1;
    check("midrst_coef_addr", coef_addr, 0);
    check("midrst_filter_out", filter_out, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    step(); step();
    rst = 1'b1;
    model_clear();
    saw_valid = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) saw_valid = 1;
      step();
    end
    check("midrst_no_valid", saw_valid, 0);
    run_sample(16'sd500, "postreset");
    check("postreset_const", filter_out, 500);

    // Saturation / wrap of the narrowed result
    set_coefs(32767, 32767, 32767, 32767);
    do_reset();
    for (int i = 1; i <= 64; i++) run_sample(16'sd32767, $sformatf("sat%0d", i));
`ifdef FIR_SATURATE_EN
    check("sat_final_const", filter_out, 32767);
`else
    check("sat_final_const", filter_out, -128);
`endif

    // Random coefficients and samples with random idle gaps
    do_reset();
    for (int k = 0; k < 64; k++) coef_rom[k] = 16'($urandom);
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      s = 16'($urandom);
      run_sample(s, $sformatf("rand%0d", i));
    end
    check("rand_no_overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
